// File: rtl/multicycle_controller.sv
// multicycle_controller: control FSM for a multicycle RV32/RV64 core.
// Steps each instruction through fetch/decode/execute/memory/writeback over a shared ALU and a
// unified memory with a ready handshake. Retire pulses on the last cycle of every instruction.
// Outputs are forced low while reset_n is asserted so that a MemReady seen during reset never
// triggers an instruction capture.
module multicycle_controller #(
    parameter int XLEN    = 64,
    parameter bit TRAP_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] Op,
    input  logic [2:0] Funct3,
    input  logic       Funct7b5,
    input  logic       Eq,
    input  logic       LT,
    input  logic       LTU,
    input  logic       MemReady,
    output logic       MemReq,
    output logic [1:0] MemRW,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ImmSrc,
    output logic [2:0] ALUSelect,
    output logic       SubArith,
    output logic       W64,
    output logic [1:0] ResultSrc,
    output logic       RegWrite,
    output logic       Illegal,
    output logic       Retire
);

    localparam logic [6:0] OP_LOAD  = 7'h03;
    localparam logic [6:0] OP_STORE = 7'h23;
    localparam logic [6:0] OP_R     = 7'h33;
    localparam logic [6:0] OP_I     = 7'h13;
    localparam logic [6:0] OP_RW    = 7'h3B;
    localparam logic [6:0] OP_IW    = 7'h1B;
    localparam logic [6:0] OP_BR    = 7'h63;
    localparam logic [6:0] OP_JAL   = 7'h6F;
    localparam logic [6:0] OP_JALR  = 7'h67;
    localparam logic [6:0] OP_LUI   = 7'h37;
    localparam logic [6:0] OP_AUIPC = 7'h17;
    localparam bit         RV64     = (XLEN == 64);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
        S_ALUWB, S_BRANCH, S_JUMP, S_JTGT, S_UPPER, S_TRAP
    } state_t;

    state_t r_state;
    state_t w_next;
    logic   w_wOp;
    logic   w_aluOp;
    logic   w_taken;

    // Opcode classification and branch-condition evaluation shared by the FSM
    always_comb begin
        w_wOp   = RV64 && ((Op == OP_RW) || (Op == OP_IW));
        w_aluOp = (Op == OP_R) || (Op == OP_I) || w_wOp;
        w_taken = 1'b0;
        case (Funct3)
            3'b000:  w_taken = Eq;
            3'b001:  w_taken = !Eq;
            3'b100:  w_taken = LT;
            3'b101:  w_taken = !LT;
            3'b110:  w_taken = LTU;
            3'b111:  w_taken = !LTU;
            default: w_taken = 1'b0;
        endcase
    end

    // State register; reset abandons any in-flight access and clears the trap
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and control outputs; everything stays low while reset is held
    always_comb begin
        w_next    = r_state;
        MemReq    = 1'b0;
        MemRW     = 2'b00;
        AdrSrc    = 1'b0;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ImmSrc    = 3'b000;
        ALUSelect = 3'b000;
        SubArith  = 1'b0;
        W64       = 1'b0;
        ResultSrc = 2'b00;
        RegWrite  = 1'b0;
        Illegal   = 1'b0;
        Retire    = 1'b0;
        if (reset_n) begin
            case (r_state)
                S_FETCH: begin
                    MemReq    = 1'b1;
                    MemRW     = 2'b10;
                    ALUSrcB   = 2'b10;
                    ResultSrc = 2'b10;
                    if (MemReady) begin
                        IRWrite = 1'b1;
                        PCWrite = 1'b1;
                        w_next  = S_DECODE;
                    end
                end
                S_DECODE: begin
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b01;
                    ImmSrc  = 3'b010;
                    if ((Op == OP_LOAD) || (Op == OP_STORE)) begin
                        w_next = S_MEMADR;
                    end else if (w_aluOp) begin
                        w_next = S_EXEC;
                    end else if (Op == OP_BR) begin
                        w_next = S_BRANCH;
                    end else if ((Op == OP_JAL) || (Op == OP_JALR)) begin
                        w_next = S_JUMP;
                    end else if ((Op == OP_LUI) || (Op == OP_AUIPC)) begin
                        w_next = S_UPPER;
                    end else begin
                        // An illegal opcode squashed to a NOP does not count as retired
                        w_next = TRAP_EN ? S_TRAP : S_FETCH;
                    end
                end
                S_MEMADR: begin
                    ALUSrcA = 2'b10;
                    ALUSrcB = 2'b01;
                    ImmSrc  = (Op == OP_STORE) ? 3'b001 : 3'b000;
                    w_next  = (Op == OP_STORE) ? S_MEMWR : S_MEMRD;
                end
                S_MEMRD: begin
                    MemReq = 1'b1;
                    MemRW  = 2'b10;
                    AdrSrc = 1'b1;
                    if (MemReady) begin
                        w_next = S_MEMWB;
                    end
                end
                S_MEMWB: begin
                    ResultSrc = 2'b01;
                    RegWrite  = 1'b1;
                    Retire    = 1'b1;
                    w_next    = S_FETCH;
                end
                S_MEMWR: begin
                    MemReq = 1'b1;
                    MemRW  = 2'b01;
                    AdrSrc = 1'b1;
                    if (MemReady) begin
                        Retire = 1'b1;
                        w_next = S_FETCH;
                    end
                end
                S_EXEC: begin
                    ALUSrcA   = 2'b10;
                    ALUSrcB   = ((Op == OP_R) || (Op == OP_RW)) ? 2'b00 : 2'b01;
                    ALUSelect = Funct3;
                    SubArith  = (Funct3 == 3'b010) || (Funct3 == 3'b011) ||
                                ((Funct3 == 3'b101) && Funct7b5) ||
                                ((Funct3 == 3'b000) && Funct7b5 && Op[5]);
                    W64       = w_wOp;
                    w_next    = S_ALUWB;
                end
                S_ALUWB: begin
                    ResultSrc = 2'b00;
                    RegWrite  = 1'b1;
                    Retire    = 1'b1;
                    w_next    = S_FETCH;
                end
                S_BRANCH: begin
                    ALUSrcA   = 2'b10;
                    ALUSrcB   = 2'b00;
                    SubArith  = 1'b1;
                    ResultSrc = 2'b00;
                    PCWrite   = w_taken;
                    Retire    = 1'b1;
                    w_next    = S_FETCH;
                end
                S_JUMP: begin
                    // Link value is OldPC + 4
                    ALUSrcA   = 2'b01;
                    ALUSrcB   = 2'b10;
                    ResultSrc = 2'b10;
                    RegWrite  = 1'b1;
                    w_next    = S_JTGT;
                end
                S_JTGT: begin
                    ALUSrcA   = (Op == OP_JALR) ? 2'b10 : 2'b01;
                    ImmSrc    = (Op == OP_JALR) ? 3'b000 : 3'b011;
                    ALUSrcB   = 2'b01;
                    ResultSrc = 2'b10;
                    PCWrite   = 1'b1;
                    Retire    = 1'b1;
                    w_next    = S_FETCH;
                end
                S_UPPER: begin
                    ALUSrcA   = (Op == OP_LUI) ? 2'b11 : 2'b01;
                    ALUSrcB   = 2'b01;
                    ImmSrc    = 3'b100;
                    ResultSrc = 2'b10;
                    RegWrite  = 1'b1;
                    Retire    = 1'b1;
                    w_next    = S_FETCH;
                end
                S_TRAP: begin
                    Illegal = 1'b1;
                end
                default: begin
                    w_next = S_FETCH;
                end
            endcase
        end
    end

endmodule
